// File: rtl/mole_ctrl_if.sv
// Handshake bundle between the whack-a-mole controller and its player/timebase side.
interface mole_ctrl_if;
   logic       start;
   logic       tick;
   logic [3:0] btn;
   logic [3:0] mole;
   logic       hit;
   logic       miss;
   logic       score_clr;
   logic [4:0] round;
   logic       busy;
   logic       done;

   modport master (
      output start, tick, btn,
      input  mole, hit, miss, score_clr, round, busy, done
   );

   modport slave (
      input  start, tick, btn,
      output mole, hit, miss, score_clr, round, busy, done
   );
endinterface

// File: rtl/mole_ctrl.sv
// Whack-a-mole game controller: lights one random hole per round, times it out
// on tick pulses, and reports hits, misses and score-clear pulses.
module mole_ctrl #(
   parameter int unsigned MOLE_TICKS = 8,
   parameter int unsigned GAP_TICKS  = 2,
   parameter int unsigned ROUNDS     = 20
) (
   input logic         clk,
   input logic         reset,
   mole_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ROUND_W = 5;
   localparam logic [3:0]  LFSR_SEED = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           lfsr;
   logic [3:0]           btn_q;
   logic [3:0]           mole_q;
   logic [CNT_W-1:0]     cnt;
   logic [ROUND_W-1:0]   round_q;

   logic [3:0] press;
   logic [3:0] mole_new;
   logic       start_ok;
   logic       hit_cond;
   logic       show_exp;
   logic       gap_exp;
   logic       last_round;

   // Shared decode used by next-state, output and datapath logic
   assign press      = bus.btn & ~btn_q;
   assign mole_new   = 4'b0001 << lfsr[1:0];
   assign start_ok   = ((state == IDLE) || (state == DONE)) && bus.start;
   assign hit_cond   = (state == SHOW) && ((press & mole_q) != 4'b0000);
   assign show_exp   = (state == SHOW) && bus.tick && (cnt == CNT_W'(MOLE_TICKS - 1));
   assign gap_exp    = (state == GAP) && bus.tick && (cnt == CNT_W'(GAP_TICKS - 1));
   assign last_round = (round_q == ROUND_W'(ROUNDS));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = SHOW;
         SHOW:    if (hit_cond || show_exp) state_nxt = GAP;
         GAP:     if (gap_exp) state_nxt = last_round ? DONE : SHOW;
         DONE:    if (start_ok) state_nxt = SHOW;
         default: state_nxt = IDLE;
      endcase
   end

   // Event pulses are Mealy and suppressed while reset is asserted
   always_comb begin
      bus.hit       = 1'b0;
      bus.miss      = 1'b0;
      bus.score_clr = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      if (!reset) begin
         bus.hit       = hit_cond;
         bus.miss      = show_exp && !hit_cond;
         bus.score_clr = start_ok;
      end
      bus.busy = (state == SHOW) || (state == GAP);
      bus.done = (state == DONE);
   end

   assign bus.mole  = mole_q;
   assign bus.round = round_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr    <= LFSR_SEED;
         btn_q   <= 4'b0000;
         mole_q  <= 4'b0000;
         cnt     <= '0;
         round_q <= '0;
      end else begin
         lfsr  <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
         btn_q <= bus.btn;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  mole_q  <= mole_new;
                  round_q <= ROUND_W'(1);
                  cnt     <= '0;
               end
            end
            SHOW: begin
               if (hit_cond || show_exp) begin
                  mole_q <= 4'b0000;
                  cnt    <= '0;
               end else if (bus.tick) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            GAP: begin
               if (gap_exp) begin
                  cnt <= '0;
                  if (!last_round) begin
                     round_q <= round_q + ROUND_W'(1);
                     mole_q  <= mole_new;
                  end
               end else if (bus.tick) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_ctrl.sv
// Directed bench for mole_ctrl with three rounds per game.
module tb_mole_ctrl;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mole_ctrl_if bus ();

   mole_ctrl #(
      .MOLE_TICKS (8),
      .GAP_TICKS  (2),
      .ROUNDS     (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   logic [3:0]  m_lfsr;
   logic [3:0]  exp_mole;
   logic [1:0]  idx;

   // Reference LFSR tracks the one inside the design, cycle for cycle
   task automatic cyc();
      @(posedge clk);
      m_lfsr = reset ? 4'b1001 : {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
      #1;
   endtask

   task automatic tick_pulse();
      bus.tick = 1'b1;
      idx = m_lfsr[1:0];
      cyc();
      bus.tick = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.tick  = 1'b0;
      bus.btn   = 4'b0000;
      cyc();
      cyc();
      #1;
      chk("rst_mole", 32'(bus.mole), 32'h0);
      chk("rst_round", 32'(bus.round), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_hit", 32'(bus.hit), 32'h0);
      chk("rst_miss", 32'(bus.miss), 32'h0);
      chk("rst_clr", 32'(bus.score_clr), 32'h0);

      // First game start right after reset release
      reset = 1'b0;
      bus.start = 1'b1;
      #1;
      chk("start_clr", 32'(bus.score_clr), 32'h1);
      cyc();
      bus.start = 1'b0;
      #1;
      chk("start_clr_off", 32'(bus.score_clr), 32'h0);
      chk("start_mole", 32'(bus.mole), 32'h2);
      chk("start_round", 32'(bus.round), 32'h1);
      chk("start_busy", 32'(bus.busy), 32'h1);

      // Hit on the lit hole, then hold the button
      bus.btn = 4'b0010;
      #1;
      chk("hit_pulse", 32'(bus.hit), 32'h1);
      chk("hit_nomiss", 32'(bus.miss), 32'h0);
      cyc();
      #1;
      chk("hit_one_cycle", 32'(bus.hit), 32'h0);
      chk("hit_mole_off", 32'(bus.mole), 32'h0);
      chk("gap_busy", 32'(bus.busy), 32'h1);
      cyc();
      #1;
      chk("hold_no_hit", 32'(bus.hit), 32'h0);
      bus.btn = 4'b0000;

      // Gap of two ticks leads into round 2
      tick_pulse();
      #1;
      chk("gap_mole_off", 32'(bus.mole), 32'h0);
      chk("gap_round1", 32'(bus.round), 32'h1);
      tick_pulse();
      #1;
      exp_mole = 4'b0001 << idx;
      chk("r2_round", 32'(bus.round), 32'h2);
      chk("r2_mole", 32'(bus.mole), 32'(exp_mole));

      // Timeout on the eighth tick
      repeat (7) tick_pulse();
      #1;
      chk("pre_to_mole", 32'(bus.mole), 32'(exp_mole));
      chk("pre_to_miss", 32'(bus.miss), 32'h0);
      bus.tick = 1'b1;
      #1;
      chk("to_miss", 32'(bus.miss), 32'h1);
      chk("to_nohit", 32'(bus.hit), 32'h0);
      cyc();
      bus.tick = 1'b0;
      #1;
      chk("to_miss_off", 32'(bus.miss), 32'h0);
      chk("to_mole_off", 32'(bus.mole), 32'h0);
      tick_pulse();
      tick_pulse();
      #1;
      exp_mole = 4'b0001 << idx;
      chk("r3_round", 32'(bus.round), 32'h3);
      chk("r3_mole_nz", 32'(bus.mole != 4'b0000), 32'h1);
      chk("r3_mole", 32'(bus.mole), 32'(exp_mole));

      // Presses on unlit holes only are ignored
      bus.btn = ~exp_mole;
      #1;
      chk("unlit_nohit", 32'(bus.hit), 32'h0);
      chk("unlit_nomiss", 32'(bus.miss), 32'h0);
      cyc();
      bus.btn = 4'b0000;
      #1;
      chk("unlit_mole_kept", 32'(bus.mole), 32'(exp_mole));
      cyc();

      // Hit coincident with expiry: hit wins
      repeat (7) tick_pulse();
      bus.tick = 1'b1;
      bus.btn  = exp_mole;
      #1;
      chk("sim_hit", 32'(bus.hit), 32'h1);
      chk("sim_nomiss", 32'(bus.miss), 32'h0);
      cyc();
      bus.tick = 1'b0;
      bus.btn  = 4'b0000;
      #1;
      chk("sim_mole_off", 32'(bus.mole), 32'h0);

      // Start is ignored mid-game
      bus.start = 1'b1;
      #1;
      chk("gap_start_ign", 32'(bus.score_clr), 32'h0);
      cyc();
      bus.start = 1'b0;
      #1;
      chk("gap_round_kept", 32'(bus.round), 32'h3);
      chk("gap_busy_kept", 32'(bus.busy), 32'h1);

      // Last gap ends the game
      tick_pulse();
      tick_pulse();
      #1;
      chk("done_flag", 32'(bus.done), 32'h1);
      chk("done_round", 32'(bus.round), 32'h3);
      chk("done_mole", 32'(bus.mole), 32'h0);
      chk("done_busy", 32'(bus.busy), 32'h0);
      repeat (5) cyc();
      #1;
      chk("done_hold", 32'(bus.done), 32'h1);

      // Restart from DONE
      bus.start = 1'b1;
      idx = m_lfsr[1:0];
      #1;
      chk("restart_clr", 32'(bus.score_clr), 32'h1);
      cyc();
      bus.start = 1'b0;
      #1;
      exp_mole = 4'b0001 << idx;
      chk("restart_clr_off", 32'(bus.score_clr), 32'h0);
      chk("restart_round", 32'(bus.round), 32'h1);
      chk("restart_mole", 32'(bus.mole), 32'(exp_mole));
      chk("restart_done", 32'(bus.done), 32'h0);

      // No ticks: mole stays lit indefinitely
      repeat (20) cyc();
      #1;
      chk("wait_mole", 32'(bus.mole), 32'(exp_mole));
      chk("wait_busy", 32'(bus.busy), 32'h1);

      // Reset with a lit-button press in the same cycle
      reset   = 1'b1;
      bus.btn = exp_mole;
      #1;
      chk("mrst_nohit", 32'(bus.hit), 32'h0);
      chk("mrst_nomiss", 32'(bus.miss), 32'h0);
      cyc();
      reset   = 1'b0;
      bus.btn = 4'b0000;
      #1;
      chk("mrst_mole", 32'(bus.mole), 32'h0);
      chk("mrst_round", 32'(bus.round), 32'h0);
      chk("mrst_busy", 32'(bus.busy), 32'h0);
      chk("mrst_done", 32'(bus.done), 32'h0);
      chk("mrst_hit", 32'(bus.hit), 32'h0);
      chk("mrst_miss", 32'(bus.miss), 32'h0);
      chk("mrst_clr", 32'(bus.score_clr), 32'h0);
      bus.start = 1'b1;
      #1;
      chk("mrst_start_clr", 32'(bus.score_clr), 32'h1);
      cyc();
      bus.start = 1'b0;
      #1;
      chk("mrst_seed_mole", 32'(bus.mole), 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mole_ctrl.md
MOLE_CTRL -- requirements
Module: mole_ctrl

Interface
REQ-001 Parameter MOLE_TICKS, default 8: ticks a mole stays lit before a miss is declared; legal range 1..15.
REQ-002 Parameter GAP_TICKS, default 2: ticks with no mole lit between rounds; legal range 1..15.
REQ-003 Parameter ROUNDS, default 20: moles per game; legal range 1..31.
REQ-004 Ports SHALL be as follows (clock and reset first):
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; starts a new game from IDLE or DONE.
- tick  in  1  one-cycle timebase enable pulse.
- btn  in  4  debounced player buttons, level, one per hole.
- mole  out  4  one-hot lit hole; 4'b0000 when no mole is lit.
- hit  out  1  one-cycle pulse per successful whack; drives the score counter's increment input.
- miss  out  1  one-cycle pulse when a mole times out.
- score_clr  out  1  one-cycle pulse on game start; drives the score counter's reset input.
- round  out  5  current round number, 1..ROUNDS; 0 in IDLE.
- busy  out  1  high in SHOW or GAP.
- done  out  1  high in DONE.

Function
REQ-005 The state machine SHALL have states IDLE, SHOW, GAP and DONE, with one state per cycle.
REQ-006 A 4-bit LFSR SHALL load seed 4'b1001 on reset, then advance every cycle (including IDLE) as next = {lfsr[2:0], lfsr[3]^lfsr[2]}.
REQ-007 The mole index SHALL be lfsr[1:0], sampled in the cycle the transition into SHOW is taken; mole SHALL equal 1<<index from the next cycle.
REQ-008 btn SHALL be registered once per cycle; press = btn & ~btn_q, giving a rising edge per button.
REQ-009 IDLE or DONE with start=1: next state SHALL be SHOW, with round=1, mole loaded, ticks counter cleared, and score_clr=1 for exactly that transition cycle.
REQ-010 SHOW hit condition is (press & mole) != 0. On a hit: hit=1 for one cycle, mole←0, ticks counter←0, next state GAP.
REQ-011 Presses on unlit buttons in SHOW SHALL be ignored; a press set containing the lit button counts as a hit.
REQ-012 In SHOW, each tick SHALL increment the ticks counter. When tick=1 and the counter equals MOLE_TICKS-1 with no hit: miss=1 for one cycle, mole←0, counter←0, next state GAP.
REQ-013 If a hit and timeout expiry occur in the same cycle, the hit SHALL win: hit=1 and miss=0.
REQ-014 In GAP, mole SHALL be 0 and presses SHALL be ignored; each tick increments the counter. On tick with counter==GAP_TICKS-1:
- if round==ROUNDS, next state DONE;
- otherwise round←round+1, new mole loaded, counter←0, next state SHOW.
REQ-015 DONE SHALL hold round at ROUNDS, mole=0 and done=1 until start=1 (see REQ-009) or reset.
REQ-016 start SHALL be ignored in SHOW and GAP.
REQ-017 hit, miss and score_clr SHALL be mutually exclusive, and each SHALL be at most one cycle wide per event.
REQ-018 Without tick pulses, the FSM SHALL wait indefinitely in SHOW or GAP; hits in SHOW are still accepted.

Reset
REQ-019 When reset=1 at a posedge, the block SHALL enter:
- state IDLE, lfsr=4'b1001;
- mole=0, round=0, ticks counter=0, btn_q=0;
- hit=0, miss=0, score_clr=0, busy=0, done=0.
REQ-020 Reset SHALL take priority over start, tick and btn in the same cycle, including mid-game in SHOW or GAP; no hit or miss pulse is emitted on that edge.

Verification
REQ-021 Start sequence: reset, then start=1 in the first cycle after reset release (lfsr=1001) -> score_clr=1 for one cycle; next cycle mole=4'b0010, round=1, busy=1.
REQ-022 Hit: mole=4'b0010, btn rises to 4'b0010 -> hit=1 for exactly one cycle, mole=0, state GAP. Holding btn high produces no second hit.
REQ-023 Timeout: mole lit and 8 tick pulses with no press -> miss=1 on the 8th tick cycle, mole=0. After 2 further ticks, round=2 and mole is non-zero.
REQ-024 Simultaneous events: lit-button press on the same cycle as the 8th tick -> hit=1, miss=0. A press on an unlit button only -> no pulse, mole stays lit.
REQ-025 Game end: ROUNDS=3, run 3 rounds -> done=1, round=3, mole=0. Then start=1 -> score_clr pulse and round=1.
REQ-026 Mid-game reset: reset=1 in SHOW with a lit-button press in the same cycle -> hit=0, all outputs 0, lfsr back to 4'b1001.
